padding: RTL and testbench

- Translates a coordinate (x, y) in a zero-padded feature-map window into a memory address for the unpadded feature map stored row-major at baseAddr.
- Flags whether the coordinate falls on a padding location, a real feature-map element, or outside the padded map.
- Sits between the convolution window scanner and the feature-map memory read port.
- Fully pipelined: one request per cycle, fixed 2-cycle latency.

---
 rtl/padding_pkg.sv | 26 ++
 rtl/padding_addr_calc.sv | 54 +++++
 rtl/padding.sv | 163 ++++++++++++++++
 tb/tb_padding.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/padding_pkg.sv
// Shared widths, element stride and result-class codes for the padding address translator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package padding_pkg;

    // Width of baseAddr / realAddr.
    localparam int ADDR_W  = 64;
    // Width of x, y, fmX, fmY.
    localparam int COORD_W = 11;
    // Width of each padding amount.
    localparam int PAD_W   = 4;

    // Address increment per feature-map element.
    localparam logic [ADDR_W-1:0] ELEM_STRIDE = ADDR_W'(1);

    // Width of the element offset dy*fmX+dx; it cannot overflow at this width.
    localparam int OFF_W   = 2 * COORD_W + 1;

    // Result classes reported on realAddrEn. Code 3 is never produced.
    typedef enum logic [1:0] {
        EN_NONE = 2'd0,   // no result, or coordinate outside the padded map
        EN_PAD  = 2'd1,   // padding location, address meaningless
        EN_FM   = 2'd2    // real feature-map element, address valid
    } addr_en_t;

endpackage : padding_pkg

// File: rtl/padding_addr_calc.sv
// Stage 2 of the translator: registers dy*fmX+dx, then scales by the stride and adds the base.
// Latency: 1 cycle from vld_i to vld_o; addr_o is combinational from the internal register.
// Backpressure: none; accepts a new operand set every cycle.
module padding_addr_calc
    import padding_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               vld_i,
    input  logic [1:0]         en_i,
    input  logic [COORD_W-1:0] dx_i,
    input  logic [COORD_W-1:0] dy_i,
    input  logic [COORD_W-1:0] fmx_i,
    input  logic [ADDR_W-1:0]  base_i,
    output logic               vld_o,
    output logic [1:0]         en_o,
    output logic [ADDR_W-1:0]  addr_o
);

    logic               vld_q,  vld_d;
    logic [1:0]         en_q,   en_d;
    logic [OFF_W-1:0]   off_q,  off_d;
    logic [ADDR_W-1:0]  base_q, base_d;

    // Element offset inside the unpadded map; dx/dy are only meaningful for EN_FM requests,
    // other classes carry a don't-care offset that the output stage masks off.
    always_comb begin
        vld_d  = vld_i;
        en_d   = en_i;
        off_d  = OFF_W'(dy_i) * OFF_W'(fmx_i) + OFF_W'(dx_i);
        base_d = base_i;
    end

    // Pipeline register; valid is flushed by reset so nothing in flight survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            en_q   <= EN_NONE;
            off_q  <= '0;
            base_q <= '0;
        end else begin
            vld_q  <= vld_d;
            en_q   <= en_d;
            off_q  <= off_d;
            base_q <= base_d;
        end
    end

    assign vld_o  = vld_q;
    assign en_o   = en_q;
    // Address arithmetic wraps modulo 2^ADDR_W.
    assign addr_o = base_q + ADDR_W'(off_q) * ELEM_STRIDE;

endmodule : padding_addr_calc

// File: rtl/padding.sv
// Maps a padded-window coordinate to a row-major feature-map address and classifies it
// (pad / feature-map / outside); outside-map detection is built only with PADDING_BOUNDS_CHECK_EN.
// Latency: fixed 2 cycles from the sampling edge; one request per cycle, no backpressure.
module padding
    import padding_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inReady,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [ADDR_W-1:0]  baseAddr,
    input  logic [COORD_W-1:0] fmX,
    input  logic [COORD_W-1:0] fmY,
    input  logic [PAD_W-1:0]   paddingUp,
    input  logic [PAD_W-1:0]   paddingDown,
    input  logic [PAD_W-1:0]   paddingLeft,
    input  logic [PAD_W-1:0]   paddingRight,
    output logic [ADDR_W-1:0]  realAddr,
    output logic [1:0]         realAddrEn,
    output logic               outReady
);

    // One extra bit so padding + size sums can never wrap.
    localparam int EXT_W = COORD_W + 1;

    logic [EXT_W-1:0] x_e, y_e, pl_e, pu_e, fmx_e, fmy_e;
    logic             in_fm, in_pad;

    assign x_e   = EXT_W'(x);
    assign y_e   = EXT_W'(y);
    assign pl_e  = EXT_W'(paddingLeft);
    assign pu_e  = EXT_W'(paddingUp);
    assign fmx_e = EXT_W'(fmX);
    assign fmy_e = EXT_W'(fmY);

    // A zero-sized dimension makes the upper bound equal the lower one, so in_fm is never set.
    assign in_fm = (x_e >= pl_e) && (x_e < pl_e + fmx_e) &&
                   (y_e >= pu_e) && (y_e < pu_e + fmy_e);

`ifdef PADDING_BOUNDS_CHECK_EN
    logic [EXT_W-1:0] pd_e, pr_e, w_ext, h_ext;

    assign pd_e  = EXT_W'(paddingDown);
    assign pr_e  = EXT_W'(paddingRight);
    assign w_ext = pl_e + fmx_e + pr_e;
    assign h_ext = pu_e + fmy_e + pd_e;

    // Only coordinates inside the full padded W x H map count as padding.
    assign in_pad = !in_fm && (x_e < w_ext) && (y_e < h_ext);
`else
    logic unused_pad_far;

    // Without the bounds check the far-side padding amounts play no role.
    assign unused_pad_far = ^{paddingDown, paddingRight};
    assign in_pad         = !in_fm;
`endif

    // ---------------------------------------------------------------- stage 1
    logic               s1_vld_q,  s1_vld_d;
    logic [1:0]         s1_en_q,   s1_en_d;
    logic [COORD_W-1:0] s1_dx_q,   s1_dx_d;
    logic [COORD_W-1:0] s1_dy_q,   s1_dy_d;
    logic [COORD_W-1:0] s1_fmx_q,  s1_fmx_d;
    logic [ADDR_W-1:0]  s1_base_q, s1_base_d;

    // Classify and capture operands; data only loads on a request so idle inputs are ignored.
    always_comb begin
        s1_vld_d  = inReady;
        s1_en_d   = s1_en_q;
        s1_dx_d   = s1_dx_q;
        s1_dy_d   = s1_dy_q;
        s1_fmx_d  = s1_fmx_q;
        s1_base_d = s1_base_q;
        if (inReady) begin
            if (in_fm) begin
                s1_en_d = EN_FM;
            end else if (in_pad) begin
                s1_en_d = EN_PAD;
            end else begin
                s1_en_d = EN_NONE;
            end
            s1_dx_d   = x - COORD_W'(paddingLeft);
            s1_dy_d   = y - COORD_W'(paddingUp);
            s1_fmx_d  = fmX;
            s1_base_d = baseAddr;
        end
    end

    // Stage-1 register with asynchronous flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_en_q   <= EN_NONE;
            s1_dx_q   <= '0;
            s1_dy_q   <= '0;
            s1_fmx_q  <= '0;
            s1_base_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_en_q   <= s1_en_d;
            s1_dx_q   <= s1_dx_d;
            s1_dy_q   <= s1_dy_d;
            s1_fmx_q  <= s1_fmx_d;
            s1_base_q <= s1_base_d;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic               s2_vld;
    logic [1:0]         s2_en;
    logic [ADDR_W-1:0]  s2_addr;

    padding_addr_calc u_addr_calc (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (s1_vld_q),
        .en_i   (s1_en_q),
        .dx_i   (s1_dx_q),
        .dy_i   (s1_dy_q),
        .fmx_i  (s1_fmx_q),
        .base_i (s1_base_q),
        .vld_o  (s2_vld),
        .en_o   (s2_en),
        .addr_o (s2_addr)
    );

    // ---------------------------------------------------------------- outputs
    logic               out_vld_q,  out_vld_d;
    logic [1:0]         out_en_q,   out_en_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;

    // Address is forced to zero unless it refers to a real feature-map element.
    always_comb begin
        out_vld_d  = s2_vld;
        out_en_d   = EN_NONE;
        out_addr_d = '0;
        if (s2_vld) begin
            out_en_d = s2_en;
            if (s2_en == EN_FM) begin
                out_addr_d = s2_addr;
            end
        end
    end

    // Registered outputs; reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_en_q   <= EN_NONE;
            out_addr_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_en_q   <= out_en_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign outReady   = out_vld_q;
    assign realAddrEn = out_en_q;
    assign realAddr   = out_addr_q;

endmodule : padding

// File: tb/tb_padding.sv
// Self-checking bench for padding: constant vector table, random requests against a
// behavioural model, and a reset-while-busy sequence; results are matched via a scoreboard.
`timescale 1ns/1ps
module tb_padding;
    import padding_pkg::*;

`ifdef PADDING_BOUNDS_CHECK_EN
    localparam logic [1:0] OOB_EN = 2'd0;
    localparam bit         BOUNDS = 1'b1;
`else
    localparam logic [1:0] OOB_EN = 2'd1;
    localparam bit         BOUNDS = 1'b0;
`endif
    localparam logic [63:0] STRIDE = 64'd1;

    logic               clk = 1'b0;
    logic               rst;
    logic               inReady;
    logic [COORD_W-1:0] x, y, fmX, fmY;
    logic [ADDR_W-1:0]  baseAddr;
    logic [PAD_W-1:0]   paddingUp, paddingDown, paddingLeft, paddingRight;
    logic [ADDR_W-1:0]  realAddr;
    logic [1:0]         realAddrEn;
    logic               outReady;

    padding dut (
        .clk          (clk),
        .rst          (rst),
        .inReady      (inReady),
        .x            (x),
        .y            (y),
        .baseAddr     (baseAddr),
        .fmX          (fmX),
        .fmY          (fmY),
        .paddingUp    (paddingUp),
        .paddingDown  (paddingDown),
        .paddingLeft  (paddingLeft),
        .paddingRight (paddingRight),
        .realAddr     (realAddr),
        .realAddrEn   (realAddrEn),
        .outReady     (outReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x, y, fmx, fmy, pu, pd, pl, pr;
        logic [63:0] base;
        logic [1:0]  en;
        logic [63:0] addr;
    } vec_t;

    typedef struct {
        int          due;
        logic [1:0]  en;
        logic [63:0] addr;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[18];
    vec_t rv;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int vx, input int vy, input logic [63:0] b,
                                input int fx, input int fy, input int pu, input int pd,
                                input int pl, input int pr, input logic [1:0] en,
                                input logic [63:0] a);
        vec_t v;
        v.x = vx; v.y = vy; v.base = b; v.fmx = fx; v.fmy = fy;
        v.pu = pu; v.pd = pd; v.pl = pl; v.pr = pr; v.en = en; v.addr = a;
        return v;
    endfunction

    // Behavioural reference used for the random requests.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   in_fm, in_map;
        r      = v;
        in_fm  = v.x >= v.pl && v.x < v.pl + v.fmx && v.y >= v.pu && v.y < v.pu + v.fmy;
        in_map = v.x < v.pl + v.fmx + v.pr && v.y < v.pu + v.fmy + v.pd;
        r.addr = 64'd0;
        if (in_fm) begin
            r.en   = 2'd2;
            r.addr = v.base + 64'((v.y - v.pu) * v.fmx + (v.x - v.pl)) * STRIDE;
        end else if (in_map || !BOUNDS) begin
            r.en = 2'd1;
        end else begin
            r.en = 2'd0;
        end
        return r;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp_v);
        end
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk({e.name, "_missed"}, 64'(cyc), 64'(e.due));
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk({e.name, "_outReady"}, 64'(outReady), 64'd1);
            chk({e.name, "_realAddrEn"}, 64'(realAddrEn), 64'(e.en));
            chk({e.name, "_realAddr"}, realAddr, e.addr);
        end else begin
            chk("idle_outReady", 64'(outReady), 64'd0);
            chk("idle_realAddrEn", 64'(realAddrEn), 64'd0);
            chk("idle_realAddr", realAddr, 64'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic drive(input vec_t v, input string nm);
        inReady      = 1'b1;
        x            = COORD_W'(v.x);
        y            = COORD_W'(v.y);
        baseAddr     = v.base;
        fmX          = COORD_W'(v.fmx);
        fmY          = COORD_W'(v.fmy);
        paddingUp    = PAD_W'(v.pu);
        paddingDown  = PAD_W'(v.pd);
        paddingLeft  = PAD_W'(v.pl);
        paddingRight = PAD_W'(v.pr);
        sb.push_back('{cyc + 3, v.en, v.addr, nm});
        step();
    endtask

    // Idle cycle with scrambled inputs that must not be sampled.
    task automatic idle();
        inReady      = 1'b0;
        x            = COORD_W'($urandom);
        y            = COORD_W'($urandom);
        baseAddr     = {$urandom, $urandom};
        fmX          = COORD_W'($urandom);
        fmY          = COORD_W'($urandom);
        paddingUp    = PAD_W'($urandom);
        paddingDown  = PAD_W'($urandom);
        paddingLeft  = PAD_W'($urandom);
        paddingRight = PAD_W'($urandom);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            x     y     base                   fmx   fmy  pu pd pl pr  en     addr
        tbl[0]  = mk(3,    2,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd2, 64'd5);
        tbl[1]  = mk(2,    4,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd2, 64'd14);
        tbl[2]  = mk(4,    5,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd2, 64'd21);
        tbl[3]  = mk(1,    3,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd1, 64'd0);
        tbl[4]  = mk(6,    3,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd2, 64'd13);
        tbl[5]  = mk(7,    3,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd1, 64'd0);
        tbl[6]  = mk(8,    8,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd1, 64'd0);
        tbl[7]  = mk(9,    0,    64'd4,                 5,    5,   2, 2, 2, 2, OOB_EN, 64'd0);
        tbl[8]  = mk(2,    2,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd2, 64'd4);
        tbl[9]  = mk(6,    6,    64'd4,                 5,    5,   2, 2, 2, 2, 2'd2, 64'd28);
        tbl[10] = mk(5,    3,    64'd100,               7,    4,   1, 0, 3, 0, 2'd2, 64'd116);
        tbl[11] = mk(0,    0,    64'h1234,              5,    5,   0, 0, 0, 0, 2'd2, 64'h1234);
        tbl[12] = mk(4,    4,    64'h1234,              5,    5,   0, 0, 0, 0, 2'd2, 64'h124C);
        tbl[13] = mk(5,    0,    64'h1234,              5,    5,   0, 0, 0, 0, OOB_EN, 64'd0);
        tbl[14] = mk(2,    3,    64'd4,                 0,    5,   2, 2, 2, 2, 2'd1, 64'd0);
        tbl[15] = mk(4,    2,    64'hFFFF_FFFF_FFFF_FFFE, 5,  5,   2, 2, 2, 2, 2'd2, 64'd0);
        tbl[16] = mk(1999, 1999, 64'd0,                 2000, 2000, 0, 0, 0, 0, 2'd2, 64'd3999999);
        tbl[17] = mk(1,    1,    64'd4,                 5,    0,   1, 1, 1, 1, 2'd1, 64'd0);

        // Reset state, including the asynchronous assertion.
        rst = 1'b0;
        inReady = 1'b0;
        x = '0; y = '0; baseAddr = '0; fmX = '0; fmY = '0;
        paddingUp = '0; paddingDown = '0; paddingLeft = '0; paddingRight = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_outReady", 64'(outReady), 64'd0);
        chk("reset_realAddrEn", 64'(realAddrEn), 64'd0);
        chk("reset_realAddr", realAddr, 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Table vectors, back to back, then idle to drain.
        for (int i = 0; i < 18; i++) drive(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 4; i++) idle();

        // Random requests with gaps and per-request configuration.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                rv.fmx  = int'($urandom_range(0, 12));
                rv.fmy  = int'($urandom_range(0, 12));
                rv.pu   = int'($urandom_range(0, 15));
                rv.pd   = int'($urandom_range(0, 15));
                rv.pl   = int'($urandom_range(0, 15));
                rv.pr   = int'($urandom_range(0, 15));
                rv.x    = int'($urandom_range(0, rv.pl + rv.fmx + rv.pr + 3));
                rv.y    = int'($urandom_range(0, rv.pu + rv.fmy + rv.pd + 3));
                rv.base = {$urandom, $urandom};
                rv      = model(rv);
                drive(rv, $sformatf("rand%0d", i));
            end
        end
        for (int i = 0; i < 4; i++) idle();

        // Reset while results are in flight and one is on the outputs.
        drive(tbl[0], "pre_rst_a");
        drive(tbl[1], "pre_rst_b");
        drive(tbl[2], "pre_rst_c");
        inReady = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_outReady", 64'(outReady), 64'd0);
        chk("midrst_realAddrEn", 64'(realAddrEn), 64'd0);
        chk("midrst_realAddr", realAddr, 64'd0);
        sb.delete();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle();
        drive(tbl[9], "post_rst");
        for (int i = 0; i < 4; i++) idle();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_padding
